// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: opcode, control-state and fetch-state definitions shared by the fetch unit and Control.
package instr_fetch_unit_pkg;
  localparam int OPCODE_W = 6;
  localparam logic [1:0] F_IDLE = 2'd0;
  localparam logic [1:0] F_REQ  = 2'd1;
  localparam logic [1:0] F_DONE = 2'd2;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  typedef enum logic [5:0] {
    OP_NOP  = 6'h00,
    OP_J    = 6'h02,
    OP_BEQ  = 6'h04,
    OP_ADDI = 6'h08,
    OP_LW   = 6'h23,
    OP_SW   = 6'h2b
  } opcode_t;
  typedef enum logic [3:0] {
    C_INSTRUCTION_FETCH,
    C_DECODE,
    C_EXECUTE,
    C_MEM_ACCESS,
    C_WRITEBACK
  } ctrl_state_t;
  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [31:0] w);
    return w[31 -: OPCODE_W];
  endfunction
endpackage

// File: rtl/instr_fetch_unit_fetch_timer.sv
// fetch_timer: counts F_REQ wait cycles and flags expiry when the memory never answers.
module fetch_timer #(
  parameter int CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);
  localparam int W = $clog2(CYCLES + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n || clear) cnt <= '0;
    else if (tick) cnt <= cnt + 1'b1;
  // fires in the CYCLES-th waiting cycle; a ready in that cycle suppresses tick, so ready wins
  assign expired = tick && cnt == W'(CYCLES - 1);
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches one instruction per request into the IR and owns the PC.
// Optional wait timeout enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_start,
  input  logic               pc_load,
  input  logic [ADDR_W-1:0]  pc_load_val,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic [ADDR_W-1:0]  pc,
  output logic               ir_valid,
  output logic               fetch_done,
  output logic               busy,
  output logic               redirect_err,
  output logic               fetch_err
);
  logic [1:0] state;
  logic timeout;
  assign mem_req = state == F_REQ;
  assign fetch_done = state == F_DONE;
  assign busy = state != F_IDLE;
  assign mem_addr = pc;
  assign opcode = instr[INSTR_W-1 -: OPCODE_W];
`ifdef FETCH_TIMEOUT_EN
  fetch_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clear(state != F_REQ),
    .tick(mem_req && !mem_ready),
    .expired(timeout)
  );
  always_ff @(posedge clk)
    if (!rst_n) fetch_err <= 1'b0;
    else if (timeout) fetch_err <= 1'b1;
`else
  assign timeout = 1'b0;
  assign fetch_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= F_IDLE;
      pc <= RESET_PC;
      instr <= '0;
      ir_valid <= 1'b0;
      redirect_err <= 1'b0;
    end else begin
      if (state == F_IDLE) begin
        if (pc_load) pc <= pc_load_val;
        if (fetch_start) begin
          state <= F_REQ;
          ir_valid <= 1'b0;
        end
      end else if (state == F_REQ) begin
        if (mem_ready) begin
          instr <= mem_rdata;
          pc <= pc + 1'b1;
          state <= F_DONE;
          ir_valid <= 1'b1;
        end else if (timeout) begin
          // substitute a NOP and leave pc alone so Control can proceed
          instr <= INSTR_W'(NOP_INSTR);
          state <= F_DONE;
          ir_valid <= 1'b1;
        end
      end else begin
        state <= F_IDLE;
      end
      if (busy && pc_load) redirect_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized self-checking bench against a transaction-level fetch model.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_start = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_val = '0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [15:0] pc;
  logic        ir_valid, fetch_done, busy, redirect_err, fetch_err;
  int checks = 0;
  int failures = 0;
  logic [15:0] m_pc;
  logic [31:0] m_ir;
  bit m_rerr;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .instr(instr), .opcode(opcode),
    .pc(pc), .ir_valid(ir_valid), .fetch_done(fetch_done), .busy(busy),
    .redirect_err(redirect_err), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Issues one fetch from idle; waits<0 means the memory never answers.
  task automatic run_fetch(input bit ld, input logic [15:0] lv, input int waits,
                           input logic [31:0] data, input bit bad_load, input logic [15:0] exp_addr,
                           output int lat, output int reqs, output int addr_bad, output int hold_bad);
    @(negedge clk);
    fetch_start = 1'b1;
    pc_load = ld;
    pc_load_val = lv;
    @(posedge clk);
    lat = 1; reqs = 0; addr_bad = 0; hold_bad = 0;
    while (lat < 60) begin
      @(negedge clk);
      if (fetch_done) break;
      if (mem_req) begin
        reqs++;
        if (mem_addr !== exp_addr) addr_bad++;
      end
      if (ir_valid) hold_bad++;
      fetch_start = 1'($urandom_range(0, 1));
      pc_load = bad_load && reqs == 1;
      pc_load_val = 16'($urandom);
      mem_ready = waits >= 0 && reqs == waits + 1;
      mem_rdata = mem_ready ? data : $urandom;
      @(posedge clk);
      lat++;
    end
    fetch_start = 1'b0;
    pc_load = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_pc = 16'h0000; m_ir = '0; m_rerr = 0;
    @(negedge clk);
    checks++;
    if ({mem_req, ir_valid, fetch_done, busy, redirect_err, fetch_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=000000", {mem_req, ir_valid, fetch_done, busy, redirect_err, fetch_err});
    end
    checks++;
    if ({pc, instr} !== {m_pc, m_ir}) begin
      failures++;
      $display("FAIL reset_pc_ir got pc=%h ir=%h want pc=%h ir=%h", pc, instr, m_pc, m_ir);
    end
  endtask

  task automatic test_basic_fetch();
    int lat, reqs, ab, hb;
    run_fetch(0, 16'h0, 0, 32'h2000_0005, 0, m_pc, lat, reqs, ab, hb);
    m_pc = m_pc + 16'd1; m_ir = 32'h2000_0005;
    checks++;
    if ({lat, reqs, ab} !== {32'd2, 32'd1, 32'd0}) begin
      failures++;
      $display("FAIL basic_timing got lat=%0d reqs=%0d addr_bad=%0d want 2 1 0", lat, reqs, ab);
    end
    checks++;
    if ({instr, opcode, pc, ir_valid, mem_req} !== {m_ir, 6'h08, m_pc, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL basic_result got ir=%h op=%h pc=%h v=%b req=%b want ir=%h op=08 pc=%h v=1 req=0",
               instr, opcode, pc, ir_valid, mem_req, m_ir, m_pc);
    end
    @(negedge clk);
    checks++;
    if ({ir_valid, fetch_done, busy, instr} !== {1'b1, 1'b0, 1'b0, m_ir}) begin
      failures++;
      $display("FAIL idle_hold got v=%b done=%b busy=%b ir=%h want v=1 done=0 busy=0 ir=%h",
               ir_valid, fetch_done, busy, instr, m_ir);
    end
  endtask

  task automatic test_wait_states();
    int lat, reqs, ab, hb;
    logic [31:0] d = $urandom;
    run_fetch(0, 16'h0, 3, d, 0, m_pc, lat, reqs, ab, hb);
    m_pc = m_pc + 16'd1; m_ir = d;
    checks++;
    if ({lat, reqs, ab, hb} !== {32'd5, 32'd4, 32'd0, 32'd0}) begin
      failures++;
      $display("FAIL wait3_timing got lat=%0d reqs=%0d addr_bad=%0d valid_in_req=%0d want 5 4 0 0", lat, reqs, ab, hb);
    end
    checks++;
    if ({instr, pc} !== {m_ir, m_pc}) begin
      failures++;
      $display("FAIL wait3_result got ir=%h pc=%h want ir=%h pc=%h", instr, pc, m_ir, m_pc);
    end
  endtask

  task automatic test_load_with_start();
    int lat, reqs, ab, hb;
    logic [31:0] d = $urandom;
    m_pc = 16'h0100;
    run_fetch(1, 16'h0100, 1, d, 0, m_pc, lat, reqs, ab, hb);
    m_pc = m_pc + 16'd1; m_ir = d;
    checks++;
    if ({lat, reqs, ab} !== {32'd3, 32'd2, 32'd0}) begin
      failures++;
      $display("FAIL load_start_addr got lat=%0d reqs=%0d addr_bad=%0d want 3 2 0", lat, reqs, ab);
    end
    checks++;
    if (pc !== 16'h0101) begin
      failures++;
      $display("FAIL load_start_pc got=%h want=0101", pc);
    end
  endtask

  task automatic test_wrap_and_redirect();
    int lat, reqs, ab, hb;
    logic [31:0] d = $urandom;
    @(negedge clk);
    pc_load = 1'b1; pc_load_val = 16'hFFFF;
    @(negedge clk);
    pc_load = 1'b0;
    m_pc = 16'hFFFF;
    checks++;
    if ({pc, redirect_err} !== {m_pc, 1'b0}) begin
      failures++;
      $display("FAIL idle_load got pc=%h rerr=%b want pc=%h rerr=0", pc, redirect_err, m_pc);
    end
    run_fetch(0, 16'h0, 2, d, 1, m_pc, lat, reqs, ab, hb);
    m_pc = m_pc + 16'd1; m_ir = d; m_rerr = 1;
    checks++;
    if ({reqs, ab} !== {32'd3, 32'd0}) begin
      failures++;
      $display("FAIL wrap_addr got reqs=%0d addr_bad=%0d want 3 0", reqs, ab);
    end
    checks++;
    if ({pc, redirect_err, instr} !== {16'h0000, 1'b1, m_ir}) begin
      failures++;
      $display("FAIL wrap_redirect got pc=%h rerr=%b ir=%h want pc=0000 rerr=1 ir=%h", pc, redirect_err, instr, m_ir);
    end
  endtask

  task automatic test_idle_noise();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    checks++;
    if ({instr, pc, ir_valid, busy} !== {m_ir, m_pc, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL idle_ready_ignored got ir=%h pc=%h v=%b busy=%b want ir=%h pc=%h v=1 busy=0",
               instr, pc, ir_valid, busy, m_ir, m_pc);
    end
  endtask

  task automatic test_random_fetches();
    int lat, reqs, ab, hb, w;
    bit ld;
    logic [15:0] lv;
    logic [31:0] d;
    for (int i = 0; i < 20; i++) begin
      ld = 1'($urandom_range(0, 1));
      lv = 16'($urandom);
      w = $urandom_range(0, 4);
      d = $urandom;
      if (ld) m_pc = lv;
      run_fetch(ld, lv, w, d, 0, m_pc, lat, reqs, ab, hb);
      m_pc = m_pc + 16'd1; m_ir = d;
      checks++;
      if ({lat, reqs, ab, hb} !== {w + 2, w + 1, 32'd0, 32'd0}) begin
        failures++;
        $display("FAIL rand%0d_timing got lat=%0d reqs=%0d addr_bad=%0d valid_in_req=%0d want %0d %0d 0 0",
                 i, lat, reqs, ab, hb, w + 2, w + 1);
      end
      checks++;
      if ({instr, opcode, pc, ir_valid, redirect_err} !== {m_ir, m_ir[31:26], m_pc, 1'b1, m_rerr}) begin
        failures++;
        $display("FAIL rand%0d_result got ir=%h op=%h pc=%h v=%b rerr=%b want ir=%h op=%h pc=%h v=1 rerr=%b",
                 i, instr, opcode, pc, ir_valid, redirect_err, m_ir, m_ir[31:26], m_pc, m_rerr);
      end
    end
  endtask

  task automatic test_reset_mid_fetch();
    @(negedge clk);
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    m_pc = 16'h0000; m_ir = '0; m_rerr = 0;
    checks++;
    if ({mem_req, busy, ir_valid, redirect_err, pc} !== {4'b0, m_pc}) begin
      failures++;
      $display("FAIL midreset got req=%b busy=%b v=%b rerr=%b pc=%h want 0 0 0 0 pc=%h",
               mem_req, busy, ir_valid, redirect_err, pc, m_pc);
    end
    rst_n = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ready = 1'b0;
    checks++;
    if ({instr, pc, busy, ir_valid} !== {m_ir, m_pc, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL late_ready got ir=%h pc=%h busy=%b v=%b want ir=%h pc=%h busy=0 v=0",
               instr, pc, busy, ir_valid, m_ir, m_pc);
    end
  endtask

  task automatic test_timeout();
    int lat, reqs, ab, hb;
    logic [31:0] d = $urandom;
`ifdef FETCH_TIMEOUT_EN
    run_fetch(0, 16'h0, -1, d, 0, m_pc, lat, reqs, ab, hb);
    checks++;
    if ({lat, reqs} !== {32'd16, 32'd15}) begin
      failures++;
      $display("FAIL timeout_timing got lat=%0d reqs=%0d want 16 15", lat, reqs);
    end
    checks++;
    if ({instr, fetch_err, pc} !== {32'h0, 1'b1, m_pc}) begin
      failures++;
      $display("FAIL timeout_result got ir=%h ferr=%b pc=%h want ir=0 ferr=1 pc=%h", instr, fetch_err, pc, m_pc);
    end
    test_reset();
    run_fetch(0, 16'h0, 14, d, 0, m_pc, lat, reqs, ab, hb);
    m_pc = m_pc + 16'd1; m_ir = d;
    checks++;
    if ({lat, instr, fetch_err, pc} !== {32'd16, m_ir, 1'b0, m_pc}) begin
      failures++;
      $display("FAIL ready_at_expiry got lat=%0d ir=%h ferr=%b pc=%h want 16 ir=%h ferr=0 pc=%h",
               lat, instr, fetch_err, pc, m_ir, m_pc);
    end
`else
    run_fetch(0, 16'h0, 20, d, 0, m_pc, lat, reqs, ab, hb);
    m_pc = m_pc + 16'd1; m_ir = d;
    checks++;
    if ({lat, instr, fetch_err, pc} !== {32'd22, m_ir, 1'b0, m_pc}) begin
      failures++;
      $display("FAIL long_wait got lat=%0d ir=%h ferr=%b pc=%h want 22 ir=%h ferr=0 pc=%h",
               lat, instr, fetch_err, pc, m_ir, m_pc);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_wait_states();
    test_load_with_start();
    test_wrap_and_redirect();
    test_idle_noise();
    test_random_fetches();
    test_reset_mid_fetch();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer side of the opcode interface consumed by the multicycle Control FSM.
- Fetches one instruction per request from instruction memory over a req/ready handshake, holds it in the instruction register (IR), and presents `opcode` and `instr` to Control and the datapath.
- Owns the PC: post-fetch increment, plus redirect loads from branch/jump resolution.

Parameters:
- ADDR_W, 16, PC / memory address width in words.
- INSTR_W, 32, instruction width; opcode is instr[INSTR_W-1 -: 6].
- RESET_PC, 0, PC value after reset.
- TIMEOUT_CYCLES, 15, max wait cycles for mem_ready; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- fetch_start  in  1  request a fetch; driven when Control enters INSTRUCTION_FETCH.
- pc_load  in  1  redirect PC (branch taken / jump).
- pc_load_val  in  ADDR_W  redirect target.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_W  read address, equals pc while mem_req=1.
- mem_ready  in  1  memory has read data valid this cycle.
- mem_rdata  in  INSTR_W  instruction data.
- instr  out  INSTR_W  IR contents.
- opcode  out  6  top 6 bits of IR.
- pc  out  ADDR_W  current PC.
- ir_valid  out  1  IR holds a completed fetch.
- fetch_done  out  1  one-cycle pulse, IR just written.
- busy  out  1  FSM not in F_IDLE.
- redirect_err  out  1  sticky: pc_load arrived while busy.
- fetch_err  out  1  timeout flag (feature only; tied 0 otherwise).

Behaviour:
- Reset, when rst_n=0 at a clock edge: state=F_IDLE, pc=RESET_PC, IR=0, ir_valid=0, fetch_done=0, mem_req=0, redirect_err=0, fetch_err=0.
  - Reset mid-fetch abandons the transaction. mem_req is 0 from the next cycle. A late mem_ready is ignored.
- FSM states, 2-bit encoding:
  - F_IDLE: mem_req=0. On fetch_start go to F_REQ, clear ir_valid.
  - F_REQ: mem_req=1, mem_addr=pc, held stable until mem_ready. On mem_ready: IR<=mem_rdata, pc<=pc+1, go to F_DONE.
  - F_DONE: fetch_done=1, ir_valid=1, mem_req=0. Unconditionally return to F_IDLE next cycle.
- Latency: fetch_start at edge N puts mem_req high in cycle N+1. With mem_ready in the first F_REQ cycle, fetch_done is high in cycle N+2.
  - Minimum 2 cycles from fetch_start to fetch_done; each wait cycle adds 1.
- ir_valid rules:
  - Stays high in F_IDLE until the next fetch_start.
  - instr and opcode are stable whenever ir_valid=1.
- PC arithmetic: unsigned ADDR_W, pc+1 wraps from all-ones to 0 with no flag.
- pc_load:
  - In F_IDLE: pc<=pc_load_val.
  - Simultaneous with fetch_start in F_IDLE: the load wins and the subsequent F_REQ uses the loaded pc.
  - In F_REQ/F_DONE: ignored, and redirect_err is set (sticky until reset).
- fetch_start while busy: ignored, no error.
- mem_ready outside F_REQ: ignored.
- mem_addr: drives pc in every state; it is valid only when mem_req=1.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Enabled:
  - Wait counter clears on entry to F_REQ and increments each F_REQ cycle without mem_ready.
  - When the counter reaches TIMEOUT_CYCLES without mem_ready: IR<=OP_NOP word (all zeros), pc is not incremented, fetch_err is set (sticky), and the FSM goes to F_DONE so Control does not hang.
  - mem_ready in the same cycle as the timeout: ready wins.
- Disabled: no counter. F_REQ waits indefinitely. fetch_err is tied 0.

Decomposition:
- Shared package/include, alongside the existing opcode and control-state definitions:
  - fetch state encoding (F_IDLE=0, F_REQ=1, F_DONE=2)
  - NOP_INSTR constant
  - opcode field position
- Sub-module: fetch_timer (counter plus compare, outputs expired), instantiated only under FETCH_TIMEOUT_EN. Everything else stays flat.

Test Plan:
1. Reset then fetch_start, memory returns 0x20000005 with zero wait: mem_req high 1 cycle, mem_addr=0x0000; fetch_done in cycle N+2; instr=0x20000005, opcode=0x08, pc=0x0001, ir_valid=1.
2. Fetch with mem_ready delayed 3 cycles: mem_req and mem_addr stable for 4 cycles, fetch_done at N+5, only one pc increment.
3. pc_load_val=0x0100 with pc_load and fetch_start in the same idle cycle: mem_addr=0x0100; after completion pc=0x0101.
4. pc=0xFFFF then fetch: mem_addr=0xFFFF, pc wraps to 0x0000. pc_load pulsed during F_REQ: pc unchanged by the load, redirect_err=1.
5. rst_n low in the second F_REQ cycle, then mem_ready arrives: mem_req=0 after that edge, pc=RESET_PC, ir_valid=0, IR unchanged by the late data.
6. FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=15, mem_ready never asserted: fetch_done after 15 F_REQ cycles, instr=0, fetch_err=1, pc unchanged. Ready and expiry in the same cycle: data captured, fetch_err stays 0.
